// File: rtl/branch_condition_unit.sv
// Resolves 8086-style jump/loop conditions from captured comparator flags and a loop count.
// Define BCU_PERF_CNT_EN to add the saturating taken_count output.
module branch_condition_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_valid,
   input  logic             bigger,
   input  logic             equal,
   input  logic             smallest,
   input  logic             cnt_load,
   input  logic [CNT_W-1:0] cnt_value,
   input  logic             cond_valid,
   output logic             cond_ready,
   input  logic [3:0]       cond_code,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             taken,
   output logic             error,
   output logic [2:0]       flags_held,
`ifdef BCU_PERF_CNT_EN
   output logic [15:0]      taken_count,
`endif
   output logic [CNT_W-1:0] cnt_out
);

   typedef enum logic [1:0] {IDLE, DEC, EVAL, HOLD} state_t;

   state_t           state_q;
   logic [2:0]       flags_q;
   logic [2:0]       eval_flags_q;
   logic [3:0]       code_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rv_q;
   logic             taken_q;
   logic             err_q;
   logic [2:0]       new_flags;
   logic             flag_ok;
   logic             flag_bad;

   function automatic logic is_onehot(input logic [2:0] f);
      return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
   endfunction

   function automatic logic resolve(input logic [3:0] code, input logic [2:0] f,
                                    input logic cnz);
      logic b, e, s;
      {b, e, s} = f;
      case (code)
         4'd0:    return e;
         4'd1:    return ~e;
         4'd2:    return b;
         4'd3:    return b | e;
         4'd4:    return s;
         4'd5:    return s | e;
         4'd6:    return 1'b1;
         4'd8:    return cnz;
         4'd9:    return cnz & e;
         4'd10:   return cnz & ~e;
         4'd11:   return ~cnz;
         default: return 1'b0;
      endcase
   endfunction

   assign new_flags = {bigger, equal, smallest};
   assign flag_ok   = flag_valid & is_onehot(new_flags);
   assign flag_bad  = flag_valid & ~is_onehot(new_flags);

   // The decrement owns the count register during DEC; a load that cycle is dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == DEC)
         cnt_d = cnt_q - CNT_W'(1);
      else if (cnt_load)
         cnt_d = cnt_value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         flags_q      <= 3'b010;
         eval_flags_q <= 3'b010;
         code_q       <= 4'd0;
         cnt_q        <= '0;
         rv_q         <= 1'b0;
         taken_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (flag_ok)
            flags_q <= new_flags;
         cnt_q <= cnt_d;
         err_q <= flag_bad | ((state_q == EVAL) && (code_q >= 4'd12));
         case (state_q)
            IDLE: begin
               if (cond_valid) begin
                  code_q <= cond_code;
                  // Snapshot with bypass so later captures cannot touch this decision.
                  eval_flags_q <= flag_ok ? new_flags : flags_q;
                  state_q <= (cond_code inside {4'd8, 4'd9, 4'd10}) ? DEC : EVAL;
               end
            end
            DEC: state_q <= EVAL;
            EVAL: begin
               taken_q <= resolve(code_q, eval_flags_q, cnt_q != '0);
               state_q <= HOLD;
            end
            HOLD: begin
               if (!rv_q) begin
                  rv_q <= 1'b1;
               end else if (result_ready) begin
                  rv_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BCU_PERF_CNT_EN
   logic [15:0] tcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcnt_q <= 16'd0;
      else if (rv_q && result_ready && taken_q && (tcnt_q != 16'hFFFF))
         tcnt_q <= tcnt_q + 16'd1;
   end

   assign taken_count = tcnt_q;
`endif

   assign cond_ready   = (state_q == IDLE);
   assign result_valid = rv_q;
   assign taken        = taken_q;
   assign error        = err_q;
   assign flags_held   = flags_q;
   assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Randomized bench for branch_condition_unit against a behavioural flag/count model.
module tb_branch_condition_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flag_valid = 1'b0;
   logic        bigger = 1'b0, equal = 1'b0, smallest = 1'b0;
   logic        cnt_load = 1'b0;
   logic [15:0] cnt_value = 16'd0;
   logic        cond_valid = 1'b0;
   logic        cond_ready;
   logic [3:0]  cond_code = 4'd0;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic        taken;
   logic        error;
   logic [2:0]  flags_held;
   logic [15:0] cnt_out;
`ifdef BCU_PERF_CNT_EN
   logic [15:0] taken_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   bit mB, mE, mS;
   int mcnt;

   branch_condition_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flag_valid(flag_valid), .bigger(bigger), .equal(equal),
      .smallest(smallest), .cnt_load(cnt_load), .cnt_value(cnt_value),
      .cond_valid(cond_valid), .cond_ready(cond_ready), .cond_code(cond_code),
      .result_valid(result_valid), .result_ready(result_ready), .taken(taken),
      .error(error), .flags_held(flags_held),
`ifdef BCU_PERF_CNT_EN
      .taken_count(taken_count),
`endif
      .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_taken(input int code);
      bit nz;
      nz = (mcnt != 0);
      case (code)
         0:  return mE;
         1:  return !mE;
         2:  return mB;
         3:  return mB || mE;
         4:  return mS;
         5:  return mS || mE;
         6:  return 1'b1;
         8:  return nz;
         9:  return nz && mE;
         10: return nz && !mE;
         11: return !nz;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      mB = 1'b0; mE = 1'b1; mS = 1'b0; mcnt = 0;
   endtask

   task automatic set_flags(input logic [2:0] f);
      bit ok;
      ok = ($countones(f) == 1);
      @(negedge clk);
      flag_valid = 1'b1; {bigger, equal, smallest} = f;
      @(negedge clk);
      flag_valid = 1'b0;
      if (ok) {mB, mE, mS} = f;
      check("flag_err", 32'(error), 32'(!ok));
      check("flags_held", 32'(flags_held), 32'({mB, mE, mS}));
      @(negedge clk);
      check("flag_err_clear", 32'(error), 32'd0);
   endtask

   task automatic load_cnt(input logic [15:0] v);
      @(negedge clk);
      cnt_load = 1'b1; cnt_value = v;
      @(negedge clk);
      cnt_load = 1'b0;
      mcnt = int'(v);
      check("cnt_load", 32'(cnt_out), mcnt);
   endtask

   task automatic do_req(input int code, input int hold, input bit disturb,
                         input bit byp, input logic [2:0] bfl);
      int lat, errs, exp_err, exp_lat;
      bit exp_t;
      logic t0;
      @(negedge clk);
      check("cond_ready_idle", 32'(cond_ready), 32'd1);
      cond_valid = 1'b1; cond_code = 4'(code);
      exp_err = 0;
      if (byp) begin
         flag_valid = 1'b1; {bigger, equal, smallest} = bfl;
         if ($countones(bfl) == 1) {mB, mE, mS} = bfl;
         else exp_err++;
      end
      if (code >= 8 && code <= 10) mcnt = (mcnt + 65535) % 65536;
      if (code >= 12) exp_err++;
      exp_t   = model_taken(code);
      exp_lat = (code >= 8 && code <= 10) ? 4 : 3;
      lat = 0; errs = 0;
      do begin
         @(negedge clk);
         cond_valid = 1'b0; flag_valid = 1'b0;
         lat++;
         errs += int'(error);
      end while (!result_valid && lat < 10);
      check("latency", lat, exp_lat);
      check("taken", 32'(taken), 32'(exp_t));
      check("err_pulses", errs, exp_err);
      check("cnt_out", 32'(cnt_out), mcnt);
      check("flags_held_req", 32'(flags_held), 32'({mB, mE, mS}));
      t0 = taken;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(result_valid), 32'd1);
         check("hold_taken", 32'(taken), 32'(t0));
         check("hold_ready", 32'(cond_ready), 32'd0);
         flag_valid = 1'b0; cnt_load = 1'b0;
         if (disturb && i == 0) begin
            flag_valid = 1'b1; {bigger, equal, smallest} = 3'b001;
            mB = 1'b0; mE = 1'b0; mS = 1'b1;
         end
         if (disturb && i == 1) begin
            cnt_load = 1'b1; cnt_value = 16'h1234; mcnt = 'h1234;
         end
         @(negedge clk);
      end
      flag_valid = 1'b0; cnt_load = 1'b0;
      if (disturb) begin
         check("hold_flags", 32'(flags_held), 32'({mB, mE, mS}));
         check("hold_cnt", 32'(cnt_out), mcnt);
         check("hold_taken_end", 32'(taken), 32'(t0));
      end
      check("rv_before_hs", 32'(result_valid), 32'd1);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("rv_after_hs", 32'(result_valid), 32'd0);
      check("ready_after_hs", 32'(cond_ready), 32'd1);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_flags", 32'(flags_held), 32'd2);
      check("rst_cnt", 32'(cnt_out), 32'd0);
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_taken", 32'(taken), 32'd0);
      check("rst_err", 32'(error), 32'd0);
      check("rst_ready", 32'(cond_ready), 32'd1);
      rst = 1'b0;

      set_flags(3'b010);
      do_req(0, 1, 0, 0, 3'b000);
      do_req(1, 1, 0, 0, 3'b000);
      set_flags(3'b100);
      for (int c = 2; c <= 5; c++) do_req(c, 0, 0, 0, 3'b000);
      set_flags(3'b001);
      for (int c = 2; c <= 5; c++) do_req(c, 0, 0, 0, 3'b000);

      load_cnt(16'h0002);
      do_req(8, 0, 0, 0, 3'b000);
      do_req(8, 0, 0, 0, 3'b000);
      do_req(8, 0, 0, 0, 3'b000);
      load_cnt(16'h0000);
      do_req(11, 0, 0, 0, 3'b000);
      do_req(13, 0, 0, 0, 3'b000);

      set_flags(3'b100);
      do_req(2, 5, 1, 0, 3'b000);
      do_req(4, 0, 0, 0, 3'b000);
      do_req(0, 0, 0, 1, 3'b010);
      set_flags(3'b110);

      set_flags(3'b100);
      load_cnt(16'h0005);
      @(negedge clk);
      cond_valid = 1'b1; cond_code = 4'd8;
      @(posedge clk);
      #1 cond_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_rv", 32'(result_valid), 32'd0);
      check("arst_cnt", 32'(cnt_out), 32'd0);
      check("arst_flags", 32'(flags_held), 32'd2);
      check("arst_ready", 32'(cond_ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      do_req(10, 1, 0, 0, 3'b000);

      for (int it = 0; it < 80; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 3)
            set_flags(3'($urandom_range(0, 7)));
         else if (r < 5)
            load_cnt(($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 2)) : 16'($urandom));
         do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0,
                $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
